// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller between the CPU memory stage and a byte-addressed data memory.
// Load hits return combinationally, load misses refill one word in a single
// extra cycle, and stores are written through while the CPU waits for mem_ready.
module dcache_ctrl #(
    parameter int SETS  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_re,
    input  logic [2:0]       cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wd,
    output logic [31:0]      cpu_rd,
    output logic             stall,
    output logic [2:0]       mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wd,
    output logic             mem_cache_hit,
    input  logic [31:0]      mem_rd,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = 32 - IDX - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_WRITE
    } state_t;

    state_t            state_q, state_d;
    logic [31:2]       addr_q, addr_d;
    logic [SETS-1:0]   valid_q, valid_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    // Line storage; tags and data are never reset, only the valid bits are.
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [31:0]       data_q [SETS];

    logic [IDX-1:0]    req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [1:0]        req_off;
    logic [IDX-1:0]    fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              is_store;
    logic              is_load;
    logic              lookup_hit;
    logic [31:0]       merged_word;

    logic              line_wr_en;
    logic [IDX-1:0]    line_wr_idx;
    logic [TAG_W-1:0]  line_wr_tag;
    logic [31:0]       line_wr_data;

    assign req_off  = cpu_addr[1:0];
    assign req_idx  = cpu_addr[IDX+1:2];
    assign req_tag  = cpu_addr[31:IDX+2];
    assign fill_idx = addr_q[IDX+1:2];
    assign fill_tag = addr_q[31:IDX+2];

    // A store code wins over a simultaneous load request.
    assign is_store   = cpu_we[0];
    assign is_load    = cpu_re & ~cpu_we[0];
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    // Word a store leaves in a hit line: whole word for sw, one byte lane for sb.
    always_comb begin
        merged_word = data_q[req_idx];
        if (cpu_we[1]) begin
            case (req_off)
                2'd0:    merged_word[7:0]   = cpu_wd[7:0];
                2'd1:    merged_word[15:8]  = cpu_wd[7:0];
                2'd2:    merged_word[23:16] = cpu_wd[7:0];
                default: merged_word[31:24] = cpu_wd[7:0];
            endcase
        end else begin
            merged_word = cpu_wd;
        end
    end

    // Next-state, line update and output decode for the IDLE/REFILL/WRITE controller.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        valid_d       = valid_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        stall         = 1'b0;
        mem_we        = 3'b000;
        mem_addr      = cpu_addr;
        mem_wd        = cpu_wd;
        mem_cache_hit = 1'b0;
        cpu_rd        = 32'h0;
        line_wr_en    = 1'b0;
        line_wr_idx   = req_idx;
        line_wr_tag   = req_tag;
        line_wr_data  = merged_word;

        case (state_q)
            S_IDLE: begin
                if (is_store) begin
                    // Memory takes the write on this edge; a hit line is patched alongside.
                    stall      = 1'b1;
                    mem_we     = cpu_we;
                    line_wr_en = lookup_hit;
                    state_d    = S_WRITE;
                end else if (is_load) begin
                    if (lookup_hit) begin
                        cpu_rd        = data_q[req_idx];
                        mem_cache_hit = 1'b1;
                        hit_cnt_d     = hit_cnt_q + CNT_W'(1);
                    end else begin
                        stall      = 1'b1;
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                        addr_d     = cpu_addr[31:2];
                        state_d    = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                // Memory data bypasses straight to the CPU while the line is filled.
                mem_addr     = {addr_q, 2'b00};
                cpu_rd       = mem_rd;
                line_wr_en   = 1'b1;
                line_wr_idx  = fill_idx;
                line_wr_tag  = fill_tag;
                line_wr_data = mem_rd;
                valid_d[fill_idx] = 1'b1;
                state_d      = S_IDLE;
            end
            S_WRITE: begin
                stall = ~mem_ready;
                if (mem_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // While reset is held the CPU must see a quiet, non-stalling cache.
        if (rst) begin
            stall      = 1'b0;
            mem_we     = 3'b000;
            cpu_rd     = 32'h0;
            line_wr_en = 1'b0;
        end
    end

    // Control state, valid bits and performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Tag and data arrays, written on refill or on a store hit.
    always_ff @(posedge clk) begin
        if (line_wr_en) begin
            tag_q[line_wr_idx]  <= line_wr_tag;
            data_q[line_wr_idx] <= line_wr_data;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed bench for dcache_ctrl with a transaction-level cache
// and memory model; a negedge compare process checks every scripted cycle.
module tb_dcache_ctrl;

    localparam int SETS  = 8;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cpu_re = 1'b0;
    logic [2:0]        cpu_we = 3'b000;
    logic [31:0]       cpu_addr = 32'h0;
    logic [31:0]       cpu_wd = 32'h0;
    logic [31:0]       cpu_rd;
    logic              stall;
    logic [2:0]        mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wd;
    logic              mem_cache_hit;
    logic [31:0]       mem_rd;
    logic              mem_ready = 1'b1;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    dcache_ctrl #(.SETS(SETS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .stall(stall),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_cache_hit(mem_cache_hit), .mem_rd(mem_rd), .mem_ready(mem_ready),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Data memory stub: asynchronous read, write on the clock edge.
    logic [31:0] mem_arr [0:255];
    logic        mem_init = 1'b1;
    assign mem_rd = mem_arr[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h0;
            mem_arr[0] <= 32'hDEADBEEF;
        end else if (mem_we[0]) begin
            if (mem_we[1]) mem_arr[mem_addr[9:2]][8*mem_addr[1:0] +: 8] <= mem_wd[7:0];
            else           mem_arr[mem_addr[9:2]] <= mem_wd;
        end
    end

    // Reference model: what the cache holds, what memory holds, event counts.
    bit          m_valid [SETS];
    logic [31:0] m_tag   [SETS];
    logic [31:0] m_data  [SETS];
    logic [31:0] m_mem   [int unsigned];
    int          m_hit  = 0;
    int          m_miss = 0;

    int checks   = 0;
    int failures = 0;

    // Expected values for the current cycle.
    logic        exp_on = 1'b0;
    logic        exp_stall = 1'b0;
    logic [2:0]  exp_we = 3'b000;
    logic        exp_rd_chk = 1'b0;
    logic [31:0] exp_rd = 32'h0;
    logic        exp_ld = 1'b0;
    logic        exp_ma_chk = 1'b0;
    logic [31:0] exp_ma = 32'h0;
    logic        exp_wd_chk = 1'b0;
    logic [31:0] exp_wd = 32'h0;
    logic        exp_mch_chk = 1'b0;
    logic [31:0] ld_seen = 32'h0;
    int          sw_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a / 4) % SETS;
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / (4 * SETS);
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] a);
        int unsigned k = a / 4;
        return m_mem.exists(k) ? m_mem[k] : 32'h0;
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] off,
                                             input logic [7:0] b);
        logic [31:0] mask = 32'hFF << (8 * off);
        return (w & ~mask) | ({24'h0, b} << (8 * off));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
        m_hit  = 0;
        m_miss = 0;
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (exp_on) begin
            chk("stall", {31'h0, stall}, {31'h0, exp_stall});
            chk("mem_we", {29'h0, mem_we}, {29'h0, exp_we});
            if (mem_we == 3'b001) sw_seen++;
            if (exp_rd_chk) chk("cpu_rd", cpu_rd, exp_rd);
            if (exp_ld) ld_seen = cpu_rd;
            if (exp_ma_chk) chk("mem_addr", mem_addr, exp_ma);
            if (exp_wd_chk) chk("mem_wd", mem_wd, exp_wd);
            if (exp_mch_chk) chk("mem_cache_hit", {31'h0, mem_cache_hit}, 32'h0);
            chk("hit_cnt", {16'h0, hit_cnt}, 32'(m_hit % 65536));
            chk("miss_cnt", {16'h0, miss_cnt}, 32'(m_miss % 65536));
        end
    end

    task automatic set_exp(input logic s, input logic [2:0] w, input logic rc, input logic [31:0] r);
        exp_on      = 1'b1;
        exp_stall   = s;
        exp_we      = w;
        exp_rd_chk  = rc;
        exp_rd      = r;
        exp_ld      = 1'b0;
        exp_ma_chk  = 1'b0;
        exp_wd_chk  = 1'b0;
        exp_mch_chk = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        cpu_re    = 1'b0;
        cpu_we    = 3'b000;
        mem_ready = 1'b1;
        set_exp(1'b0, 3'b000, 1'b1, 32'h0);
    endtask

    task automatic do_load(input logic [31:0] a);
        int unsigned i = idx_of(a);
        logic [31:0] w;
        cpu_re = 1'b1; cpu_we = 3'b000; cpu_addr = a; cpu_wd = 32'h0;
        if (m_valid[i] && m_tag[i] == tag_of(a)) begin
            set_exp(1'b0, 3'b000, 1'b1, m_data[i]);
            exp_ld = 1'b1;
            step();
            m_hit++;
        end else begin
            set_exp(1'b1, 3'b000, 1'b0, 32'h0);
            step();
            m_miss++;
            w = m_word(a);
            set_exp(1'b0, 3'b000, 1'b1, w);
            exp_ld = 1'b1; exp_ma_chk = 1'b1; exp_ma = a & ~32'h3; exp_mch_chk = 1'b1;
            step();
            m_valid[i] = 1'b1; m_tag[i] = tag_of(a); m_data[i] = w;
        end
        go_idle();
    endtask

    task automatic do_store(input logic [31:0] a, input logic [2:0] code, input logic [31:0] d,
                            input int waits, input logic re);
        int unsigned i = idx_of(a);
        cpu_re = re; cpu_we = code; cpu_addr = a; cpu_wd = d;
        mem_ready = 1'b0;
        set_exp(1'b1, code, 1'b0, 32'h0);
        exp_ma_chk = 1'b1; exp_ma = a; exp_wd_chk = 1'b1; exp_wd = d;
        step();
        if (code == 3'b011) begin
            m_mem[a / 4] = put_byte(m_word(a), a[1:0], d[7:0]);
            if (m_valid[i] && m_tag[i] == tag_of(a)) m_data[i] = put_byte(m_data[i], a[1:0], d[7:0]);
        end else begin
            m_mem[a / 4] = d;
            if (m_valid[i] && m_tag[i] == tag_of(a)) m_data[i] = d;
        end
        for (int k = 0; k < waits; k++) begin
            set_exp(1'b1, 3'b000, 1'b0, 32'h0);
            step();
        end
        mem_ready = 1'b1;
        set_exp(1'b0, 3'b000, 1'b0, 32'h0);
        step();
        go_idle();
    endtask

    task automatic idle_cycle();
        go_idle();
        step();
    endtask

    initial begin
        m_reset();
        m_mem[32'h10000 / 4] = 32'hDEADBEEF;

        // Reset with a load pending: the cache must stay quiet.
        cpu_re = 1'b1; cpu_addr = 32'h10000;
        set_exp(1'b0, 3'b000, 1'b1, 32'h0);
        step();
        step();
        rst = 1'b0; mem_init = 1'b0;
        idle_cycle();

        // Test 1: miss then hit.
        do_load(32'h10000);
        chk("t1_refill_rd", ld_seen, 32'hDEADBEEF);
        do_load(32'h10000);
        go_idle();
        @(negedge clk);
        chk("t1_hit_cnt", {16'h0, hit_cnt}, 32'd1);
        chk("t1_miss_cnt", {16'h0, miss_cnt}, 32'd1);
        step();

        // Test 2: sb into a cached word, then reload.
        do_store(32'h10001, 3'b011, 32'h000000AB, 0, 1'b0);
        do_load(32'h10000);
        chk("t2_sb_hit_rd", ld_seen, 32'hDEADABEF);

        // Test 3: conflicting lines in set 0 (0x10060 evicts first).
        do_load(32'h10060);
        do_load(32'h10000);
        do_load(32'h10020);
        do_load(32'h10000);
        idle_cycle();
        go_idle();
        @(negedge clk);
        chk("t3_miss_cnt", {16'h0, miss_cnt}, 32'd5);
        chk("t3_hit_cnt", {16'h0, hit_cnt}, 32'd2);
        step();

        // Test 4: sw to an uncached word with cpu_re also high (store wins, no allocate).
        do_store(32'h10040, 3'b001, 32'h12345678, 1, 1'b1);
        do_load(32'h10040);
        chk("t4_nwa_rd", ld_seen, 32'h12345678);
        go_idle();
        @(negedge clk);
        chk("t4_miss_cnt", {16'h0, miss_cnt}, 32'd6);
        step();

        // Test 5: reset asserted during REFILL.
        cpu_re = 1'b1; cpu_we = 3'b000; cpu_addr = 32'h10000;
        set_exp(1'b1, 3'b000, 1'b0, 32'h0);
        step();
        m_miss++;
        rst = 1'b1;
        m_reset();
        set_exp(1'b0, 3'b000, 1'b1, 32'h0);
        step();
        rst = 1'b0;
        idle_cycle();
        do_load(32'h10000);
        chk("t5_rd_after_rst", ld_seen, 32'hDEADABEF);
        go_idle();
        @(negedge clk);
        chk("t5_miss_cnt", {16'h0, miss_cnt}, 32'd1);
        chk("t5_hit_cnt", {16'h0, hit_cnt}, 32'd0);
        step();

        // Test 6: store held by mem_ready=0 for 3 cycles; issued exactly once.
        sw_seen = 0;
        do_store(32'h10000, 3'b001, 32'hCAFEF00D, 3, 1'b0);
        chk("t6_sw_issued_once", 32'(sw_seen), 32'd1);
        do_load(32'h10000);
        chk("t6_hit_rd", ld_seen, 32'hCAFEF00D);
        idle_cycle();

        exp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
